vc_input_datapath: RTL and testbench

VC_INPUT_DATAPATH -- requirements
Module: vc_input_datapath

---
 rtl/vc_input_datapath_pkg.sv | 26 ++
 rtl/vc_input_datapath_fifo.sv | 50 +++++
 rtl/vc_input_datapath.sv | 140 ++++++++++++++
 tb/tb_vc_input_datapath.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_input_datapath_pkg.sv
// Shared definitions for the virtual-channel input datapath: default sizes,
// VC index width helper, flit record and output FSM state encoding.
package vc_input_datapath_pkg;

  localparam int DEF_FLIT_DATA_W = 34;
  localparam int DEF_N_VC        = 3;
  localparam int DEF_VC_DEPTH    = 4;

  // Width of a VC index; never narrower than one bit.
  function automatic int vc_w_f(input int n_vc);
    return (n_vc > 1) ? $clog2(n_vc) : 1;
  endfunction

  // One buffered flit: packet-tail marker plus payload.
  typedef struct packed {
    logic                       last;
    logic [DEF_FLIT_DATA_W-1:0] data;
  } s_flit_t;

  // Output arbitration FSM: IDLE picks a VC, BUSY streams one packet from it.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } e_state_t;

endpackage

// File: rtl/vc_input_datapath_fifo.sv
// Per-VC flit buffer: DEPTH-entry FIFO with extra-MSB wrapping pointers.
// The head entry is read straight from storage; a pushed flit is visible
// at the head only after the clock edge that writes it (no bypass).
module vc_fifo #(
  parameter int ENTRY_W = 35,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [ENTRY_W-1:0] i_entry,
  output logic [ENTRY_W-1:0] o_head,
  output logic               o_full,
  output logic               o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr == {~r_rd_ptr[PW-1], r_rd_ptr[PW-2:0]});
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset flushes the buffer by zeroing both pointers.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_entry;
  end

endmodule

// File: rtl/vc_input_datapath.sv
// Virtual-channel input datapath: demultiplexes incoming flits into per-VC
// FIFOs and drains them one whole packet at a time with round-robin VC choice.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. fin_ready_o may depend combinationally on fin_vc_i. Once
// fout_valid_o is high its vc/data/last stay fixed until the transfer;
// fout_ready_i has no effect while fout_valid_o is low.
module vc_input_datapath
  import vc_input_datapath_pkg::*;
#(
  parameter  int FLIT_DATA_W = DEF_FLIT_DATA_W,
  parameter  int N_VC        = DEF_N_VC,
  parameter  int VC_DEPTH    = DEF_VC_DEPTH,
  localparam int VC_W        = vc_w_f(N_VC)
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   fin_valid_i,
  input  logic [VC_W-1:0]        fin_vc_i,
  input  logic                   fin_last_i,
  input  logic [FLIT_DATA_W-1:0] fin_data_i,
  output logic                   fin_ready_o,
  output logic                   fout_valid_o,
  output logic [VC_W-1:0]        fout_vc_o,
  output logic                   fout_last_o,
  output logic [FLIT_DATA_W-1:0] fout_data_o,
  input  logic                   fout_ready_i,
  output logic [N_VC-1:0]        vc_full_o,
  output logic [N_VC-1:0]        vc_empty_o,
  output logic                   err_vc_o,
  output logic                   dbg_state_o,
  output logic [VC_W-1:0]        dbg_grant_o,
  output logic [VC_W-1:0]        dbg_rr_ptr_o
);

  localparam int ENTRY_W = FLIT_DATA_W + 1;

  e_state_t           r_state;
  logic [VC_W-1:0]    r_grant;
  logic [VC_W-1:0]    r_rr_ptr;

  logic [ENTRY_W-1:0] w_head [N_VC];
  logic [ENTRY_W-1:0] w_sel_head;
  logic [N_VC-1:0]    w_push;
  logic [N_VC-1:0]    w_pop;
  logic [N_VC-1:0]    w_full;
  logic [N_VC-1:0]    w_empty;
  logic               w_vc_ok;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_xfer;
  logic               w_pick_found;
  logic [VC_W-1:0]    w_pick_vc;
  logic [VC_W-1:0]    w_cand;
  logic [VC_W-1:0]    w_rr_next;

  // Input side: out-of-range VCs are never accepted and flag an error.
  assign w_vc_ok     = (int'(fin_vc_i) < N_VC);
  assign w_in_ready  = arst & w_vc_ok & ~w_full[fin_vc_i];
  assign w_accept    = fin_valid_i & w_in_ready;
  assign fin_ready_o = w_in_ready;
  assign err_vc_o    = arst & fin_valid_i & ~w_vc_ok;

  for (genvar g = 0; g < N_VC; g++) begin : g_vc
    assign w_push[g] = w_accept & (fin_vc_i == VC_W'(g));
    assign w_pop[g]  = w_xfer & (r_grant == VC_W'(g));

    vc_fifo #(
      .ENTRY_W (ENTRY_W),
      .DEPTH   (VC_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .arst    (arst),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_entry ({fin_last_i, fin_data_i}),
      .o_head  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  assign vc_full_o  = w_full;
  assign vc_empty_o = w_empty;

  // Output side: the granted FIFO head is presented only while BUSY.
  assign w_sel_head   = w_head[r_grant];
  assign fout_valid_o = (r_state == ST_BUSY) & ~w_empty[r_grant];
  assign fout_vc_o    = r_grant;
  assign fout_data_o  = w_sel_head[FLIT_DATA_W-1:0];
  assign fout_last_o  = w_sel_head[FLIT_DATA_W];
  assign w_xfer       = fout_valid_o & fout_ready_i;

  assign w_rr_next = (r_grant == VC_W'(N_VC - 1)) ? '0 : r_grant + VC_W'(1);

  // Round-robin search: scan offsets high to low so the nearest VC at or
  // after rr_ptr is the one left standing.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_vc    = '0;
    w_cand       = '0;
    for (int i = N_VC - 1; i >= 0; i--) begin
      w_cand = VC_W'((int'(r_rr_ptr) + i) % N_VC);
      if (!w_empty[w_cand]) begin
        w_pick_found = 1'b1;
        w_pick_vc    = w_cand;
      end
    end
  end

  // Packet arbitration FSM: latch a grant in IDLE, release it after the tail.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_found) begin
            r_grant <= w_pick_vc;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_xfer && fout_last_o) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= w_rr_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state_o  = r_state;
  assign dbg_grant_o  = r_grant;
  assign dbg_rr_ptr_o = r_rr_ptr;

endmodule

// File: tb/tb_vc_input_datapath.sv
// Self-checking bench for vc_input_datapath (N_VC=3, VC_DEPTH=4, 34-bit data).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vc_input_datapath;

  localparam int W = 35;

  logic        clk;
  logic        arst;
  logic        fin_valid_i;
  logic [1:0]  fin_vc_i;
  logic        fin_last_i;
  logic [33:0] fin_data_i;
  logic        fin_ready_o;
  logic        fout_valid_o;
  logic [1:0]  fout_vc_o;
  logic        fout_last_o;
  logic [33:0] fout_data_o;
  logic        fout_ready_i;
  logic [2:0]  vc_full_o;
  logic [2:0]  vc_empty_o;
  logic        err_vc_o;
  logic        dbg_state_o;
  logic [1:0]  dbg_grant_o;
  logic [1:0]  dbg_rr_ptr_o;

  int n_cmp = 0;
  int n_err = 0;

  vc_input_datapath dut (
    .clk          (clk),
    .arst         (arst),
    .fin_valid_i  (fin_valid_i),
    .fin_vc_i     (fin_vc_i),
    .fin_last_i   (fin_last_i),
    .fin_data_i   (fin_data_i),
    .fin_ready_o  (fin_ready_o),
    .fout_valid_o (fout_valid_o),
    .fout_vc_o    (fout_vc_o),
    .fout_last_o  (fout_last_o),
    .fout_data_o  (fout_data_o),
    .fout_ready_i (fout_ready_i),
    .vc_full_o    (vc_full_o),
    .vc_empty_o   (vc_empty_o),
    .err_vc_o     (err_vc_o),
    .dbg_state_o  (dbg_state_o),
    .dbg_grant_o  (dbg_grant_o),
    .dbg_rr_ptr_o (dbg_rr_ptr_o)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks (enter and leave on a falling edge) ----------------
  task automatic push(input logic [1:0] vc, input logic [33:0] data, input logic last,
                      input string name);
    fin_valid_i = 1'b1;
    fin_vc_i    = vc;
    fin_data_i  = data;
    fin_last_i  = last;
    #1;
    chk(name, fin_ready_o, 1'b1);
    @(posedge clk);
    @(negedge clk);
    fin_valid_i = 1'b0;
  endtask

  task automatic wait_out(input logic [1:0] vc, input logic [33:0] data, input logic last,
                          input string name);
    int t = 0;
    fout_ready_i = 1'b1;
    while (!fout_valid_o && t < 20) begin
      @(posedge clk);
      @(negedge clk);
      t++;
    end
    chk({name, "_valid"}, fout_valid_o, 1'b1);
    if (fout_valid_o) begin
      chk({name, "_vc"}, fout_vc_o, vc);
      chk({name, "_data"}, fout_data_o, data);
      chk({name, "_last"}, fout_last_o, last);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  vc;
    logic [33:0] data;
    logic        exp_ready;
    logic        exp_err;
    logic [1:0]  exp_rr;
  } s_vec_t;

  s_vec_t vecs [5];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q0 [$];
  logic [W-1:0] exp_q1 [$];
  logic [W-1:0] exp_q2 [$];
  logic [W-1:0] exp_flit;
  logic [W-1:0] prev_flit;
  logic [1:0]   prev_vc;
  logic         prev_stall;
  logic         new_rdy;
  logic [2:0]   need_tail;
  logic         done;
  int           iter;
  int           qsz;

  initial begin
    vecs[0] = '{vc: 2'd1, data: 34'h0_0000_1234, exp_ready: 1'b1, exp_err: 1'b0, exp_rr: 2'd2};
    vecs[1] = '{vc: 2'd0, data: 34'h3_0000_00A5, exp_ready: 1'b1, exp_err: 1'b0, exp_rr: 2'd1};
    vecs[2] = '{vc: 2'd2, data: 34'h0_FFFF_FFFF, exp_ready: 1'b1, exp_err: 1'b0, exp_rr: 2'd0};
    vecs[3] = '{vc: 2'd3, data: 34'h1_5555_5555, exp_ready: 1'b0, exp_err: 1'b1, exp_rr: 2'd0};
    vecs[4] = '{vc: 2'd2, data: 34'h2_AAAA_AAAA, exp_ready: 1'b1, exp_err: 1'b0, exp_rr: 2'd0};

    // ---- reset state ----
    arst         = 1'b0;
    fin_valid_i  = 1'b1;
    fin_vc_i     = 2'd0;
    fin_last_i   = 1'b0;
    fin_data_i   = '0;
    fout_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_fout_valid", fout_valid_o, 1'b0);
    chk("rst_fin_ready", fin_ready_o, 1'b0);
    chk("rst_empty", vc_empty_o, 3'b111);
    chk("rst_full", vc_full_o, 3'b000);
    chk("rst_state", dbg_state_o, 1'b0);
    chk("rst_grant", dbg_grant_o, 2'd0);
    chk("rst_rr", dbg_rr_ptr_o, 2'd0);
    fin_vc_i = 2'd3;
    #1;
    chk("rst_err", err_vc_o, 1'b0);
    fin_valid_i = 1'b0;
    arst        = 1'b1;
    @(negedge clk);

    // ---- table: single-flit packets, fout_ready held high ----
    fout_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fin_valid_i = 1'b1;
      fin_vc_i    = vecs[i].vc;
      fin_data_i  = vecs[i].data;
      fin_last_i  = 1'b1;
      #1;
      chk("tbl_ready", fin_ready_o, vecs[i].exp_ready);
      chk("tbl_err", err_vc_o, vecs[i].exp_err);
      @(posedge clk);
      @(negedge clk);
      fin_valid_i = 1'b0;
      chk("tbl_idle_cycle_valid", fout_valid_o, 1'b0);
      @(posedge clk);
      @(negedge clk);
      if (vecs[i].exp_ready) begin
        chk("tbl_out_valid", fout_valid_o, 1'b1);
        chk("tbl_out_vc", fout_vc_o, vecs[i].vc);
        chk("tbl_out_data", fout_data_o, vecs[i].data);
        chk("tbl_out_last", fout_last_o, 1'b1);
      end else begin
        chk("tbl_bad_vc_valid", fout_valid_o, 1'b0);
        chk("tbl_bad_vc_empty", vc_empty_o, 3'b111);
      end
      @(posedge clk);
      @(negedge clk);
      chk("tbl_state_idle", dbg_state_o, 1'b0);
      chk("tbl_rr", dbg_rr_ptr_o, vecs[i].exp_rr);
      chk("tbl_empty_after", vc_empty_o, 3'b111);
    end

    // ---- VC0 fills up: 5th flit held until one pop ----
    fout_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(2'd0, 34'h100 + 34'(i), 1'b0, "full_push_ready");
    fin_valid_i = 1'b1;
    fin_vc_i    = 2'd0;
    fin_data_i  = 34'h104;
    fin_last_i  = 1'b1;
    #1;
    chk("full_5th_refused", fin_ready_o, 1'b0);
    chk("full_flag", vc_full_o, 3'b001);
    chk("full_head_valid", fout_valid_o, 1'b1);
    chk("full_head_data", fout_data_o, 34'h100);
    @(posedge clk);
    @(negedge clk);
    chk("full_still_refused", fin_ready_o, 1'b0);
    fout_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fout_ready_i = 1'b0;
    #1;
    chk("full_ready_after_pop", fin_ready_o, 1'b1);
    chk("full_next_head", fout_data_o, 34'h101);
    @(posedge clk);
    @(negedge clk);
    fin_valid_i = 1'b0;
    chk("full_again", vc_full_o, 3'b001);
    for (int i = 1; i < 5; i++) wait_out(2'd0, 34'h100 + 34'(i), (i == 4), "full_drain");
    chk("full_rr", dbg_rr_ptr_o, 2'd1);

    // ---- round robin from rr_ptr=2: VC2 packet before VC0 packet ----
    fout_ready_i = 1'b0;
    push(2'd1, 34'h2A, 1'b1, "rr_push_a");
    push(2'd0, 34'hD0, 1'b1, "rr_push_d");
    push(2'd2, 34'hC0, 1'b0, "rr_push_c0");
    push(2'd2, 34'hC1, 1'b0, "rr_push_c1");
    push(2'd2, 34'hC2, 1'b1, "rr_push_c2");
    chk("rr_grant_vc1", dbg_grant_o, 2'd1);
    wait_out(2'd1, 34'h2A, 1'b1, "rr_out_a");
    chk("rr_ptr_2", dbg_rr_ptr_o, 2'd2);
    wait_out(2'd2, 34'hC0, 1'b0, "rr_out_c0");
    wait_out(2'd2, 34'hC1, 1'b0, "rr_out_c1");
    wait_out(2'd2, 34'hC2, 1'b1, "rr_out_c2");
    wait_out(2'd0, 34'hD0, 1'b1, "rr_out_d");
    chk("rr_ptr_end", dbg_rr_ptr_o, 2'd1);

    // ---- reset while BUSY with two flits buffered ----
    fout_ready_i = 1'b0;
    push(2'd1, 34'h51, 1'b0, "rst_push0");
    push(2'd1, 34'h52, 1'b0, "rst_push1");
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy_valid", fout_valid_o, 1'b1);
    chk("rst_busy_state", dbg_state_o, 1'b1);
    fin_valid_i = 1'b1;
    fin_vc_i    = 2'd0;
    arst        = 1'b0;
    #1;
    chk("arst_valid", fout_valid_o, 1'b0);
    chk("arst_empty", vc_empty_o, 3'b111);
    chk("arst_full", vc_full_o, 3'b000);
    chk("arst_ready", fin_ready_o, 1'b0);
    chk("arst_state", dbg_state_o, 1'b0);
    fin_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    arst = 1'b1;
    chk("arst_rr", dbg_rr_ptr_o, 2'd0);
    push(2'd0, 34'h99, 1'b1, "post_rst_push");
    wait_out(2'd0, 34'h99, 1'b1, "post_rst_out");

    // ---- random backpressure with per-VC scoreboard ----
    prev_stall = 1'b0;
    prev_vc    = '0;
    prev_flit  = '0;
    need_tail  = '0;
    done       = 1'b0;
    iter       = 0;
    fout_ready_i = 1'b0;
    while (!done && iter < 1500) begin
      if (prev_stall) begin
        chk("bp_hold_valid", fout_valid_o, 1'b1);
        chk("bp_hold_vc", fout_vc_o, prev_vc);
        chk("bp_hold_flit", {fout_last_o, fout_data_o}, prev_flit);
      end
      new_rdy      = 1'($urandom_range(0, 1));
      fout_ready_i = new_rdy;
      if (fout_valid_o && new_rdy) begin
        case (fout_vc_o)
          2'd0:    qsz = exp_q0.size();
          2'd1:    qsz = exp_q1.size();
          default: qsz = exp_q2.size();
        endcase
        chk("bp_q_nonempty", (qsz != 0), 1'b1);
        if (qsz != 0) begin
          case (fout_vc_o)
            2'd0:    exp_flit = exp_q0.pop_front();
            2'd1:    exp_flit = exp_q1.pop_front();
            default: exp_flit = exp_q2.pop_front();
          endcase
          chk("bp_flit", {fout_last_o, fout_data_o}, exp_flit);
        end
      end
      prev_stall = fout_valid_o & ~new_rdy;
      prev_vc    = fout_vc_o;
      prev_flit  = {fout_last_o, fout_data_o};

      fin_valid_i = 1'b0;
      if (iter < 300) begin
        if ($urandom_range(0, 2) != 0) begin
          fin_valid_i = 1'b1;
          fin_vc_i    = 2'($urandom_range(0, 2));
          fin_data_i  = {2'($urandom_range(0, 3)), 32'($urandom)};
          fin_last_i  = ($urandom_range(0, 3) == 0);
        end
      end else begin
        for (int v = 0; v < 3; v++) begin
          if (!fin_valid_i && need_tail[v] && !vc_full_o[v]) begin
            fin_valid_i = 1'b1;
            fin_vc_i    = 2'(v);
            fin_data_i  = {2'($urandom_range(0, 3)), 32'($urandom)};
            fin_last_i  = 1'b1;
          end
        end
      end
      #1;
      if (fin_valid_i && fin_ready_o) begin
        case (fin_vc_i)
          2'd0:    exp_q0.push_back({fin_last_i, fin_data_i});
          2'd1:    exp_q1.push_back({fin_last_i, fin_data_i});
          default: exp_q2.push_back({fin_last_i, fin_data_i});
        endcase
        need_tail[fin_vc_i] = ~fin_last_i;
      end
      iter++;
      if (iter >= 300 && need_tail == 3'b000 &&
          exp_q0.size() == 0 && exp_q1.size() == 0 && exp_q2.size() == 0)
        done = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    fin_valid_i  = 1'b0;
    fout_ready_i = 1'b0;
    chk("bp_drained", done, 1'b1);
    chk("bp_final_empty", vc_empty_o, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
